alu_mul_seq: RTL and testbench
==============================

ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 SHALL have parameter N, default 64, operand/ALU data width.
REQ-002 SHALL have ports: clk  in  1  single clock, rising-edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  request multiply of op_a*op_b; sampled only in IDLE.
REQ-005 op_a  in  N  multiplicand; op_b  in  N  multiplier (unsigned).
REQ-006 busy  out  1  high in ADD and SHIFT states.
REQ-007 done  out  1  one-cycle pulse, product/ovf valid.
REQ-008 product  out  N  low N bits of result; ovf  out  1  sticky, result exceeded N bits.
REQ-009 alu_a, alu_b  out  N  ALU operands; alu_fs  out  5  ALU function select; alu_c0  out  1  ALU carry-in.
REQ-010 alu_f  in  N  ALU result; alu_status  in  4  ALU flags {V,C,N,Z}, bit 2 = carry-out.

Function
REQ-011 The ALU is external and combinational; alu_a/alu_b/alu_fs/alu_c0 SHALL be driven combinationally from state and internal registers, and alu_f/alu_status SHALL be captured at the end of the same cycle.
REQ-012 States: IDLE, ADD, SHIFT, DONE.
REQ-013 IDLE & start: acc<=0, mcand<=op_a, mplr<=op_b, cnt<=0, ovf<=0; next = ADD if op_b[0] else SHIFT.
REQ-014 ADD: alu_a=acc, alu_b=mcand, alu_fs=01000, alu_c0=0; acc<=alu_f; ovf set if alu_status[2]=1; next SHIFT.
REQ-015 SHIFT: alu_a=mcand, alu_b=1, alu_fs=10000; mcand<=alu_f; mplr<=mplr>>1; cnt<=cnt+1.
REQ-016 SHIFT SHALL set ovf if mcand[N-1]=1 and (mplr>>1)!=0.
REQ-017 SHIFT exit: cnt==N-1 -> DONE; else next = ADD if mplr[1] else SHIFT.
REQ-018 DONE: done=1, product<=acc; next IDLE unconditionally.
REQ-019 IDLE and DONE SHALL drive alu_a=0, alu_b=0, alu_fs=00000, alu_c0=0.
REQ-020 start SHALL be ignored outside IDLE; op_a/op_b SHALL be sampled only at acceptance.
REQ-021 product and ovf SHALL hold until the next DONE; back-to-back start accepted in the IDLE cycle after DONE.
REQ-022 Latency (no early exit): popcount(op_b)+N cycles in ADD/SHIFT, done in the following cycle.

Reset
REQ-023 rst_n low SHALL immediately force state=IDLE and acc, mcand, mplr, cnt, product, ovf, busy, done to 0, including mid-operation; no partial result is reported.
REQ-024 First start SHALL be accepted on the first rising edge with rst_n high.

Configuration
REQ-025 Macro ALU_MUL_SEQ_EARLY_EXIT_EN defined: SHIFT SHALL also go to DONE when (mplr>>1)==0.
REQ-026 Macro undefined: exactly N SHIFT cycles per operation, no early exit.

Structure
REQ-027 Shared package SHALL hold the state enum and FS constants FS_AND=00000, FS_OR=00100, FS_ADD=01000, FS_XOR=01100, FS_SHL=10000, FS_SHR=10100, plus status bit index constants.
REQ-028 One sub-module is natural: alu_mul_seq_ctr (log2(N)-bit iteration counter with terminal-count flag); the ALU SHALL NOT be instantiated inside.

Verification
REQ-029 Bench SHALL pair the block with the LEGv8 ALU and cover:
- op_a=3, op_b=5, early exit on: ADD,SHIFT,SHIFT,ADD,SHIFT, done 6 cycles after start; product=15, ovf=0.
- Same, early exit off: done 67 cycles after start; product=15, ovf=0.
- op_a=1, op_b=FFFF_FFFF_FFFF_FFFF: product=FFFF_FFFF_FFFF_FFFF, ovf=0.
- op_a=8000_0000_0000_0000, op_b=2: product=0, ovf=1.
- op_b=0, early exit on: one SHIFT, done 2 cycles after start, product=0; start held high during busy ignored.
- rst_n low during ADD of 3*5: busy=done=product=0 immediately; new 2*7 afterwards gives product=14.

Source files
------------

// File: rtl/alu_mul_seq_pkg.sv
// Shared types and constants for the shift-and-add multiplier and its external ALU.
package alu_mul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_OR  = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_XOR = 5'b01100;
    localparam logic [4:0] FS_SHL = 5'b10000;
    localparam logic [4:0] FS_SHR = 5'b10100;

    // Bit positions inside the ALU status word {V,C,N,Z}
    localparam int STATUS_V = 3;
    localparam int STATUS_C = 2;
    localparam int STATUS_N = 1;
    localparam int STATUS_Z = 0;

endpackage

// File: rtl/alu_mul_seq_ctr.sv
// Iteration counter for the multiplier; tc flags the last of N shift steps.
module alu_mul_seq_ctr #(
    parameter int N = 64,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == W'(N - 1));

endmodule

// File: rtl/alu_mul_seq.sv
// Sequential shift-and-add multiplier driving an external combinational ALU.
// Optional feature: define ALU_MUL_SEQ_EARLY_EXIT_EN to stop once no multiplier bits remain.
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] product,
    output logic         ovf,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [4:0]   alu_fs,
    output logic         alu_c0,
    input  logic [N-1:0] alu_f,
    input  logic [3:0]   alu_status
);

    state_t       state;
    state_t       next_state;
    logic [N-1:0] acc;
    logic [N-1:0] mcand;
    logic [N-1:0] mplr;
    logic         ovf_acc;
    logic         cnt_tc;
    logic         early_exit;
    logic         shift_ovf;
    logic         accept;
    logic         load_result;
    logic         unused_status;

    assign unused_status = ^{alu_status[STATUS_V], alu_status[STATUS_N], alu_status[STATUS_Z]};

    assign accept    = (state == IDLE) && start;
    // A multiplicand bit falling off the top only matters if a later multiplier bit would add it.
    assign shift_ovf = mcand[N-1] && (mplr[N-1:1] != '0);

`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
    assign early_exit = (mplr[N-1:1] == '0);
`else
    assign early_exit = 1'b0;
`endif

    alu_mul_seq_ctr #(.N(N)) u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .inc   (state == SHIFT),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = op_b[0] ? ADD : SHIFT;
            ADD:     next_state = SHIFT;
            SHIFT: begin
                if (cnt_tc || early_exit) next_state = DONE;
                else                      next_state = mplr[1] ? ADD : SHIFT;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        alu_a  = '0;
        alu_b  = '0;
        alu_fs = FS_AND;
        alu_c0 = 1'b0;
        unique case (state)
            ADD: begin
                busy   = 1'b1;
                alu_a  = acc;
                alu_b  = mcand;
                alu_fs = FS_ADD;
            end
            SHIFT: begin
                busy   = 1'b1;
                alu_a  = mcand;
                alu_b  = N'(1);
                alu_fs = FS_SHL;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Result registers load on the way into DONE so they are already valid while done is high.
    assign load_result = (state == SHIFT) && (next_state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            mcand   <= '0;
            mplr    <= '0;
            ovf_acc <= 1'b0;
            product <= '0;
            ovf     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc     <= '0;
                        mcand   <= op_a;
                        mplr    <= op_b;
                        ovf_acc <= 1'b0;
                    end
                end
                ADD: begin
                    acc <= alu_f;
                    if (alu_status[STATUS_C]) ovf_acc <= 1'b1;
                end
                SHIFT: begin
                    mcand <= alu_f;
                    mplr  <= mplr >> 1;
                    if (shift_ovf) ovf_acc <= 1'b1;
                    if (load_result) begin
                        product <= acc;
                        ovf     <= ovf_acc | shift_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq paired with a behavioural LEGv8-style ALU.
// Expected latency follows ALU_MUL_SEQ_EARLY_EXIT_EN when the bench is built with it.
module tb_alu_mul_seq;

    localparam int N = 64;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] product;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [N-1:0] product;
        logic         ovf;
        int           lat;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic         busy;
    logic         done;
    logic [N-1:0] product;
    logic         ovf;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [4:0]   alu_fs;
    logic         alu_c0;
    logic [N-1:0] alu_f;
    logic [3:0]   alu_status;
    logic [N:0]   alu_sum;

    int           assertCount = 0;
    int           failCount   = 0;
    exp_t         sb[$];
    logic [N-1:0] lastProd = '0;
    logic         lastOvf  = 1'b0;

    alu_mul_seq #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .ovf        (ovf),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_fs     (alu_fs),
        .alu_c0     (alu_c0),
        .alu_f      (alu_f),
        .alu_status (alu_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: {V,C,N,Z} status, carry only meaningful for add
    always_comb begin
        alu_sum    = {1'b0, alu_a} + {1'b0, alu_b} + {{N{1'b0}}, alu_c0};
        alu_f      = '0;
        alu_status = '0;
        case (alu_fs)
            5'b00000: alu_f = alu_a & alu_b;
            5'b00100: alu_f = alu_a | alu_b;
            5'b01000: alu_f = alu_sum[N-1:0];
            5'b01100: alu_f = alu_a ^ alu_b;
            5'b10000: alu_f = alu_a << alu_b[5:0];
            5'b10100: alu_f = alu_a >> alu_b[5:0];
            default:  alu_f = '0;
        endcase
        if (alu_fs == 5'b01000) begin
            alu_status[3] = (alu_a[N-1] == alu_b[N-1]) && (alu_f[N-1] != alu_a[N-1]);
            alu_status[2] = alu_sum[N];
        end
        alu_status[1] = alu_f[N-1];
        alu_status[0] = (alu_f == '0);
    end

    function automatic int expLat(input logic [N-1:0] b);
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
        int msb;
        msb = -1;
        for (int i = 0; i < N; i++) if (b[i]) msb = i;
        if (b == '0) return 2;
        return $countones(b) + msb + 2;
`else
        return $countones(b) + N + 1;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [N-1:0] actual, input logic [N-1:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drives a request at the current (negedge) time and records what must come back
    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic [N-1:0] expProd, input logic expOvf);
        exp_t e;
        e.product = expProd;
        e.ovf     = expOvf;
        e.lat     = expLat(b);
        sb.push_back(e);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
    endtask

    task automatic waitResult(input bit holdStart);
        exp_t e;
        int   cycles;
        bit   seen;
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 400) begin
            @(negedge clk);
            cycles++;
            if (!holdStart) start = 1'b0;
            if (done) begin
                seen = 1'b1;
            end else begin
                checkOutput("busy during op", N'(busy), N'(1));
                checkOutput("product held", product, lastProd);
                if (holdStart) begin
                    op_a = ~op_a;
                    op_b = {$urandom, $urandom};
                end
            end
        end
        start = 1'b0;
        e = sb.pop_front();
        if (!seen) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL timeout: no done after %0d cycles, expected %0d", cycles, e.lat);
            return;
        end
        checkOutput("latency", N'(cycles), N'(e.lat));
        checkOutput("product", product, e.product);
        checkOutput("ovf", N'(ovf), N'(e.ovf));
        checkOutput("busy at done", N'(busy), '0);
        lastProd = e.product;
        lastOvf  = e.ovf;
        @(negedge clk);
        checkOutput("done one-shot", N'(done), '0);
        checkOutput("idle after done", N'(busy), '0);
        checkOutput("product kept", product, lastProd);
    endtask

    initial begin
        vec_t         vecs[7];
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic [2*N-1:0] full;

        vecs[0] = '{a: 64'd3,                   b: 64'd5,                   product: 64'd15,                  ovf: 1'b0};
        vecs[1] = '{a: 64'd1,                   b: 64'hFFFF_FFFF_FFFF_FFFF, product: 64'hFFFF_FFFF_FFFF_FFFF, ovf: 1'b0};
        vecs[2] = '{a: 64'h8000_0000_0000_0000, b: 64'd2,                   product: 64'd0,                   ovf: 1'b1};
        vecs[3] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'hFFFF_FFFF_FFFF_FFFF, product: 64'd1,                   ovf: 1'b1};
        vecs[4] = '{a: 64'h1_0000_0000,         b: 64'h1_0000_0000,         product: 64'd0,                   ovf: 1'b1};
        vecs[5] = '{a: 64'h4000_0000_0000_0000, b: 64'd3,                   product: 64'hC000_0000_0000_0000, ovf: 1'b0};
        vecs[6] = '{a: 64'd123456789,           b: 64'd1000,                product: 64'd123456789000,        ovf: 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", N'(busy), '0);
        checkOutput("reset done", N'(done), '0);
        checkOutput("reset product", product, '0);
        checkOutput("reset ovf", N'(ovf), '0);
        checkOutput("idle alu_a", alu_a, '0);
        checkOutput("idle alu_b", alu_b, '0);
        checkOutput("idle alu_fs", N'(alu_fs), '0);
        checkOutput("idle alu_c0", N'(alu_c0), '0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].product, vecs[i].ovf);
            waitResult(1'b0);
        end

        for (int i = 0; i < 4; i++) begin
            ra   = {$urandom, $urandom};
            rb   = N'($urandom);
            full = {{N{1'b0}}, ra} * {{N{1'b0}}, rb};
            applyStimulus(ra, rb, full[N-1:0], |full[2*N-1:N]);
            waitResult(1'b0);
        end

        // Zero multiplier with start held high and operands scrambled while busy
        applyStimulus(64'd99, 64'd0, 64'd0, 1'b0);
        waitResult(1'b1);

        applyStimulus(64'd6, 64'd7, 64'd42, 1'b0);
        waitResult(1'b0);

        // Reset in the first ADD cycle of 3*5 must discard the operation
        applyStimulus(64'd3, 64'd5, 64'd15, 1'b0);
        @(negedge clk);
        start = 1'b0;
        checkOutput("add busy", N'(busy), N'(1));
        checkOutput("add alu_fs", N'(alu_fs), N'(5'b01000));
        checkOutput("add alu_a", alu_a, '0);
        checkOutput("add alu_b", alu_b, 64'd3);
        checkOutput("add alu_c0", N'(alu_c0), '0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midop reset busy", N'(busy), '0);
        checkOutput("midop reset done", N'(done), '0);
        checkOutput("midop reset product", product, '0);
        checkOutput("midop reset ovf", N'(ovf), '0);
        checkOutput("midop reset alu_fs", N'(alu_fs), '0);
        void'(sb.pop_back());
        lastProd = '0;
        lastOvf  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(64'd2, 64'd7, 64'd14, 1'b0);
        waitResult(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
